decode: RTL
===========

DECODE -- requirements
Module: decode

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 if_id_instr  input  32  instruction from fetch stage's IF/ID register.
REQ-004 if_id_npc  input  32  PC+4 of that instruction, from IF/ID register.
REQ-005 mem_wb_reg_write  input  1  writeback enable from MEM/WB.
REQ-006 mem_wb_write_reg  input  5  writeback destination register index.
REQ-007 mem_wb_write_data  input  32  writeback data.
REQ-008 id_ex_wb  output  2  {RegWrite, MemtoReg}.
REQ-009 id_ex_m  output  3  {Branch, MemRead, MemWrite}.
REQ-010 id_ex_ex  output  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-011 id_ex_npc  output  32  registered if_id_npc.
REQ-012 id_ex_readdat1 / id_ex_readdat2  output  32 each  registered rs / rt register-file reads.
REQ-013 id_ex_sign_ext  output  32  registered sign-extended instr[15:0].
REQ-014 id_ex_instr_2016 / id_ex_instr_1511  output  5 each  registered rt / rd fields.

Function
REQ-015 The block SHALL contain a 32 x 32-bit register file with two combinational read ports (rs = instr[25:21], rt = instr[20:16]) and one write port.
REQ-016 Register-file write SHALL occur on the rising edge when mem_wb_reg_write=1 and mem_wb_write_reg != 0; writes to r0 SHALL be discarded and r0 SHALL always read 0.
REQ-017 When a read index equals mem_wb_write_reg with a qualifying write in the same cycle, the read SHALL return mem_wb_write_data (write-before-read bypass).
REQ-018 Control SHALL be decoded from opcode instr[31:26]: 0x00 R-type -> wb=2'b10, m=3'b000, ex=4'b1100.
REQ-019 0x23 lw -> wb=2'b11, m=3'b010, ex=4'b0001.
REQ-020 0x2B sw -> wb=2'b00, m=3'b001, ex=4'b0001.
REQ-021 0x04 beq -> wb=2'b00, m=3'b100, ex=4'b0010.
REQ-022 Any other opcode SHALL decode to all-zero control (bubble); data fields still latch normally.
REQ-023 Sign extension SHALL replicate instr[15] into bits [31:16].
REQ-024 All id_ex_* outputs SHALL be registered; latency from if_id_* valid to id_ex_* valid is exactly one clock edge, new values every cycle (no stall/flush inputs).
REQ-025 Read data latched into id_ex_readdat1/2 SHALL reflect any write occurring on that same edge (per REQ-017).

Reset
REQ-026 While rst=1 at a rising edge, all id_ex_* outputs SHALL be 0 and all 32 registers SHALL be cleared to 0.
REQ-027 rst SHALL take priority over a simultaneous mem_wb write; that write is lost.
REQ-028 Reset asserted mid-stream SHALL zero state on that edge; decode resumes on the first edge after rst deasserts using then-current if_id inputs.

Verification
REQ-029 Reset: rst=1 two cycles with arbitrary inputs -> every id_ex_* output 0; any subsequent read of r1..r31 returns 0.
REQ-030 R-type: write r1=0x000000AA, r2=0x00000055 via mem_wb, then if_id_instr=0x00221820, if_id_npc=0x00000008 -> next edge id_ex_readdat1=0xAA, readdat2=0x55, instr_2016=2, instr_1511=3, wb=2'b10, m=3'b000, ex=4'b1100, npc=0x8.
REQ-031 lw/beq: 0x8C220004 -> sign_ext=0x00000004, wb=2'b11, m=3'b010, ex=4'b0001; 0x1022FFFF -> sign_ext=0xFFFFFFFF, wb=2'b00, m=3'b100, ex=4'b0010.
REQ-032 Bypass: mem_wb writes r1=0x00000077 in same cycle as if_id_instr=0x00221820 -> next edge id_ex_readdat1=0x77.
REQ-033 r0 protection: mem_wb write r0=0xFFFFFFFF, then instr with rs=0 -> id_ex_readdat1=0.
REQ-034 Unknown opcode 0x3F -> wb=0, m=0, ex=0; reset asserted one cycle mid-sequence -> outputs 0 that cycle, correct decode resumes the following cycle.

Source files
------------

// File: rtl/decode.sv
// ID stage of a 5-stage MIPS pipeline: register file with write-before-read bypass,
// main control decode and the ID/EX pipeline register.
`timescale 1ns/1ps
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_npc,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic [31:0] mem_wb_write_data,
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_readdat1,
    output logic [31:0] id_ex_readdat2,
    output logic [31:0] id_ex_sign_ext,
    output logic [4:0]  id_ex_instr_2016,
    output logic [4:0]  id_ex_instr_1511
);
    logic [31:0] r_regs [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_wr_en;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [1:0]  w_wb;
    logic [2:0]  w_m;
    logic [3:0]  w_ex;

    assign w_op    = if_id_instr[31:26];
    assign w_rs    = if_id_instr[25:21];
    assign w_rt    = if_id_instr[20:16];
    assign w_wr_en = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

    // A same-cycle writeback to the read index wins over the stored value.
    always_comb begin
        w_rd1 = r_regs[w_rs];
        w_rd2 = r_regs[w_rt];
        if (w_wr_en && (mem_wb_write_reg == w_rs)) w_rd1 = mem_wb_write_data;
        if (w_wr_en && (mem_wb_write_reg == w_rt)) w_rd2 = mem_wb_write_data;
        if (w_rs == 5'd0) w_rd1 = 32'd0;
        if (w_rt == 5'd0) w_rd2 = 32'd0;
    end

    always_comb begin
        w_wb = 2'b00;
        w_m  = 3'b000;
        w_ex = 4'b0000;
        case (w_op)
            6'h00: begin w_wb = 2'b10; w_m = 3'b000; w_ex = 4'b1100; end
            6'h23: begin w_wb = 2'b11; w_m = 3'b010; w_ex = 4'b0001; end
            6'h2B: begin w_wb = 2'b00; w_m = 3'b001; w_ex = 4'b0001; end
            6'h04: begin w_wb = 2'b00; w_m = 3'b100; w_ex = 4'b0010; end
            default: begin w_wb = 2'b00; w_m = 3'b000; w_ex = 4'b0000; end
        endcase
    end

    // Reset outranks a simultaneous writeback, so that write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
            id_ex_wb         <= 2'b00;
            id_ex_m          <= 3'b000;
            id_ex_ex         <= 4'b0000;
            id_ex_npc        <= 32'd0;
            id_ex_readdat1   <= 32'd0;
            id_ex_readdat2   <= 32'd0;
            id_ex_sign_ext   <= 32'd0;
            id_ex_instr_2016 <= 5'd0;
            id_ex_instr_1511 <= 5'd0;
        end else begin
            if (w_wr_en) r_regs[mem_wb_write_reg] <= mem_wb_write_data;
            id_ex_wb         <= w_wb;
            id_ex_m          <= w_m;
            id_ex_ex         <= w_ex;
            id_ex_npc        <= if_id_npc;
            id_ex_readdat1   <= w_rd1;
            id_ex_readdat2   <= w_rd2;
            id_ex_sign_ext   <= {{16{if_id_instr[15]}}, if_id_instr[15:0]};
            id_ex_instr_2016 <= w_rt;
            id_ex_instr_1511 <= if_id_instr[15:11];
        end
    end
endmodule
